pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Owns the 5-bit program counter and sequences instruction fetch and execute for the BRISC core.
- Sits between the program loader (load_done), instruction memory (imem_*) and the execute stage (exec_valid/exec_done, jump_*).
- Folds jump handling into a registered, handshaked FSM so that no jump request is lost or taken twice.

Parameters:
- ADDR_W, 5, width of program counter and jump address.
- LAST_ADDR, 31, highest legal instruction address; end of program.
- MEM_LAT, 1, instruction memory read latency in cycles (legal range 1..7).

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- load_done  in  1  level; program memory contents are valid.
- run  in  1  level; start/continue execution.
- imem_rd  out  1  one-cycle read strobe to instruction memory.
- imem_addr  out  ADDR_W  read address, equal to program_counter.
- exec_valid  out  1  fetched instruction is presented to the execute stage.
- exec_done  in  1  execute stage has finished the current instruction.
- jump_en  in  1  taken jump; sampled only when exec_done=1.
- jump_address  in  ADDR_W  jump target; sampled with jump_en.
- halt_req  in  1  halt instruction executed; sampled only when exec_done=1.
- program_counter  out  ADDR_W  current instruction address.
- running  out  1  high in FETCH/WAIT/EXEC.
- halted  out  1  high in HALT.

Behaviour:
- One clock, CLK. RST is synchronous and active-high; it has priority over everything else.
- Reset values:
  - state=IDLE, program_counter=0, wait counter=0.
  - imem_rd=0, exec_valid=0, running=0, halted=0.
- States: IDLE, FETCH, WAIT, EXEC, HALT. All outputs are registered or decoded from state only; there are no combinational paths from inputs to outputs.
- IDLE: when load_done=1 and run=1 -> FETCH. Otherwise stay in IDLE; program_counter holds 0.
- FETCH (1 cycle): imem_rd=1, imem_addr=program_counter; load wait counter with MEM_LAT-1; -> WAIT.
- WAIT: decrement the counter each cycle; on the cycle it reads 0 -> EXEC. Latency from the FETCH cycle to the first exec_valid cycle is exactly MEM_LAT+1 cycles.
- EXEC: exec_valid=1 and held until exec_done=1. In the exec_done cycle, resolve in this priority order:
  1. halt_req=1 -> HALT; program_counter unchanged.
  2. jump_en=1 -> program_counter<=jump_address, -> FETCH. A jump to the current address is legal and refetches it.
  3. program_counter==LAST_ADDR -> HALT; program_counter unchanged (see Optional Feature).
  4. Otherwise program_counter<=program_counter+1, -> FETCH.
- exec_valid drops to 0 in the cycle after exec_done.
- jump_en and halt_req asserted while exec_done=0 are ignored. Nothing is latched, so each jump is taken exactly once.
- run=0 while running: the instruction in flight completes. On the exec_done cycle, if no halt or jump is pending, -> IDLE with program_counter preserved. A later run=1 resumes from that address.
- load_done falling in any non-IDLE state has priority over everything except RST:
  - -> IDLE next cycle, program_counter<=0.
  - imem_rd and exec_valid deassert that same next cycle.
- HALT: halted=1. Stay in HALT while run=1; run=0 -> IDLE with program_counter<=0.
- Arithmetic: PC increment is modulo 2^ADDR_W. With the default LAST_ADDR the increment never wraps, because address 31 ends the program.

Optional Feature:
- Macro: PC_SEQ_WRAP_EN.
- Defined: reaching LAST_ADDR with no jump and no halt sets program_counter<=0 and goes -> FETCH (continuous looping). HALT is entered only via halt_req.
- Undefined: reaching LAST_ADDR goes -> HALT as specified above.

Test Plan:
- Straight-line run: RST, then load_done=1, run=1; MEM_LAT=1; execute stage returns exec_done 2 cycles after each exec_valid -> imem_addr steps 0,1,2,...,31; halted=1 after exec_done at PC 31; exactly 32 imem_rd pulses; each fetch is followed by exec_valid 2 cycles later.
- Jump: at PC 4, exec_done=1 with jump_en=1, jump_address=20 -> next imem_addr=20, then 21; address 5 is never fetched.
- Ignored jump: jump_en=1, jump_address=9 pulsed while exec_valid=1 and exec_done=0, then exec_done alone at PC 6 -> next PC=7.
- Priority: at PC 10, exec_done, halt_req and jump_en (address 3) all asserted together -> HALT with program_counter=10 and no further imem_rd. Then run=0 -> IDLE with program_counter=0.
- Abort: load_done dropped during WAIT at PC 12 -> next cycle state IDLE, program_counter=0, exec_valid never asserted for address 12. RST asserted mid-EXEC -> all outputs at reset values next cycle.
- Wrap: with PC_SEQ_WRAP_EN defined, exec_done at PC 31 with no jump -> next imem_addr=0 and halted stays 0. Without the macro, the same stimulus gives halted=1.

Source files
------------

// File: rtl/pc_sequencer.sv
// pc_sequencer: program counter owner and fetch/execute sequencer for BRISC.
// Walks IDLE -> FETCH -> WAIT -> EXEC and back, and folds jump/halt handling
// into the EXEC handshake so that each jump is acted on exactly once.
// Optional build macro PC_SEQ_WRAP_EN: when defined, finishing LAST_ADDR
// loops back to address 0 instead of halting.
module pc_sequencer #(
    parameter int ADDR_W    = 5,
    parameter int LAST_ADDR = 31,
    parameter int MEM_LAT   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load_done,
    input  logic              run,
    output logic              imem_rd,
    output logic [ADDR_W-1:0] imem_addr,
    output logic              exec_valid,
    input  logic              exec_done,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_address,
    input  logic              halt_req,
    output logic [ADDR_W-1:0] program_counter,
    output logic              running,
    output logic              halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_WAIT  = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(LAST_ADDR);
    // Counter is loaded in FETCH and the WAIT state exits when it reads 0,
    // giving MEM_LAT WAIT cycles between the read strobe and EXEC.
    localparam logic [2:0]        WAIT_INIT = 3'(MEM_LAT - 1);

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [2:0]        r_wait_cnt;
    logic [2:0]        w_wait_next;
    logic              r_imem_rd;
    logic              r_exec_valid;
    logic              r_running;
    logic              r_halted;

    // Next-state, next-PC and wait-counter decision for the sequencer.
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_wait_next  = r_wait_cnt;
        case (r_state)
            S_IDLE: begin
                if (load_done && run) begin
                    w_state_next = S_FETCH;
                end
            end
            S_FETCH: begin
                w_wait_next  = WAIT_INIT;
                w_state_next = S_WAIT;
            end
            S_WAIT: begin
                if (r_wait_cnt == 3'd0) begin
                    w_state_next = S_EXEC;
                end else begin
                    w_wait_next = r_wait_cnt - 3'd1;
                end
            end
            S_EXEC: begin
                // jump_en/halt_req mean nothing until the execute stage
                // reports completion, so nothing is ever latched early.
                if (exec_done) begin
                    if (halt_req) begin
                        w_state_next = S_HALT;
                    end else if (jump_en) begin
                        w_pc_next    = jump_address;
                        w_state_next = S_FETCH;
                    end else if (!run) begin
                        w_state_next = S_IDLE;
                    end else if (r_pc == LAST) begin
`ifdef PC_SEQ_WRAP_EN
                        w_pc_next    = '0;
                        w_state_next = S_FETCH;
`else
                        w_state_next = S_HALT;
`endif
                    end else begin
                        w_pc_next    = r_pc + ADDR_W'(1);
                        w_state_next = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                if (!run) begin
                    w_pc_next    = '0;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        // Losing the program image aborts whatever is in flight.
        if ((r_state != S_IDLE) && !load_done) begin
            w_state_next = S_IDLE;
            w_pc_next    = '0;
            w_wait_next  = 3'd0;
        end
    end

    // State, PC and output registers; outputs are decoded from the next state
    // so they line up with the state they describe and never see inputs directly.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_wait_cnt   <= 3'd0;
            r_imem_rd    <= 1'b0;
            r_exec_valid <= 1'b0;
            r_running    <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_wait_cnt   <= w_wait_next;
            r_imem_rd    <= (w_state_next == S_FETCH);
            r_exec_valid <= (w_state_next == S_EXEC);
            r_running    <= (w_state_next == S_FETCH) ||
                            (w_state_next == S_WAIT)  ||
                            (w_state_next == S_EXEC);
            r_halted     <= (w_state_next == S_HALT);
        end
    end

    assign imem_rd         = r_imem_rd;
    assign imem_addr       = r_pc;
    assign program_counter = r_pc;
    assign exec_valid      = r_exec_valid;
    assign running         = r_running;
    assign halted          = r_halted;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: self-checking bench for pc_sequencer (MEM_LAT=1).
// Transaction-level reference: an expected program counter and halted flag
// advanced once per completed instruction; cycle timing checked per fetch.
module tb_pc_sequencer;

    localparam int MEM_LAT = 1;
    localparam int LAST    = 31;
`ifdef PC_SEQ_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       RST;
    logic       load_done;
    logic       run;
    logic       imem_rd;
    logic [4:0] imem_addr;
    logic       exec_valid;
    logic       exec_done;
    logic       jump_en;
    logic [4:0] jump_address;
    logic       halt_req;
    logic [4:0] program_counter;
    logic       running;
    logic       halted;

    pc_sequencer #(.ADDR_W(5), .LAST_ADDR(LAST), .MEM_LAT(MEM_LAT)) dut (
        .CLK(CLK), .RST(RST), .load_done(load_done), .run(run),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .exec_valid(exec_valid),
        .exec_done(exec_done), .jump_en(jump_en), .jump_address(jump_address),
        .halt_req(halt_req), .program_counter(program_counter),
        .running(running), .halted(halted)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [4:0] m_pc;
    bit         m_halt;
    int         fetch_cnt;
    bit         fetched[32];

    typedef struct {
        int         dly;
        bit         ign;
        bit         jmp;
        logic [4:0] ja;
        bit         hlt;
        logic [4:0] exp_pc;
        bit         exp_halt;
    } vec_t;
    vec_t vt[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: what the next instruction address is after one completes.
    function automatic void model_step(input bit jmp, input logic [4:0] ja, input bit hlt);
        if (hlt) m_halt = 1'b1;
        else if (jmp) m_pc = ja;
        else if (int'(m_pc) == LAST) begin
            if (WRAP) m_pc = 5'd0;
            else m_halt = 1'b1;
        end else m_pc = 5'((int'(m_pc) + 1) % 32);
    endfunction

    task automatic wait_fetch(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (imem_rd === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
        end
        chk("fetch_seen", 0, 1);
    endtask

    task automatic wait_exec(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (exec_valid === 1'b1) begin
                ok = 1'b1;
                return;
            end
            @(negedge CLK);
        end
        chk("exec_seen", 0, 1);
    endtask

    // One full instruction: fetch, latency check, hold, completion.
    task automatic do_instr(input int dly, input bit ign, input bit jmp,
                            input logic [4:0] ja, input bit hlt);
        bit ok;
        wait_fetch(ok);
        if (!ok) return;
        chk("fetch_addr", imem_addr, m_pc);
        fetched[imem_addr] = 1'b1;
        fetch_cnt++;
        for (int k = 0; k < MEM_LAT; k++) begin
            @(negedge CLK);
            chk("wait_no_valid", {imem_rd, exec_valid}, 0);
        end
        @(negedge CLK);
        chk("exec_valid_lat", exec_valid, 1);
        chk("exec_pc", program_counter, m_pc);
        for (int d = 0; d < dly; d++) begin
            exec_done    = 1'b0;
            jump_en      = ign;
            jump_address = ign ? 5'd9 : 5'd0;
            halt_req     = ign;
            @(negedge CLK);
            chk("exec_hold", {imem_rd, exec_valid, running}, 3'b011);
        end
        exec_done    = 1'b1;
        jump_en      = jmp;
        jump_address = ja;
        halt_req     = hlt;
        @(negedge CLK);
        exec_done = 1'b0;
        jump_en   = 1'b0;
        halt_req  = 1'b0;
        model_step(jmp, ja, hlt);
        $display("instr: pc_next=%0d halted=%0d exp_pc=%0d exp_halted=%0d",
                 program_counter, halted, m_pc, m_halt);
        chk("exec_valid_drop", exec_valid, 0);
        chk("pc_next", program_counter, m_pc);
        chk("halted", halted, m_halt);
        if (!m_halt) chk("refetch", imem_rd, 1);
    endtask

    // From HALT: no more fetches, then run=0 returns to IDLE at address 0.
    task automatic leave_halt();
        int rd_seen;
        rd_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (imem_rd === 1'b1) rd_seen++;
        end
        chk("halt_no_fetch", rd_seen, 0);
        chk("halt_level", {halted, running}, 2'b10);
        run = 1'b0;
        @(negedge CLK);
        chk("halt_exit_pc", program_counter, 0);
        chk("halt_exit_flags", {halted, running, imem_rd}, 0);
        run    = 1'b1;
        m_pc   = 5'd0;
        m_halt = 1'b0;
    endtask

    initial begin
        bit ok;
        int cnt;
        RST = 1'b1; load_done = 1'b0; run = 1'b0;
        exec_done = 1'b0; jump_en = 1'b0; jump_address = 5'd0; halt_req = 1'b0;
        m_pc = 5'd0; m_halt = 1'b0; fetch_cnt = 0;
        foreach (fetched[i]) fetched[i] = 1'b0;

        // directed table (jump, ignored jump, priority)
        vt[0] = '{1, 1'b0, 1'b0, 5'd0,  1'b0, 5'd1,  1'b0};
        vt[1] = '{0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd2,  1'b0};
        vt[2] = '{2, 1'b0, 1'b0, 5'd0,  1'b0, 5'd3,  1'b0};
        vt[3] = '{0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd4,  1'b0};
        vt[4] = '{1, 1'b0, 1'b1, 5'd20, 1'b0, 5'd20, 1'b0};
        vt[5] = '{0, 1'b0, 1'b0, 5'd0,  1'b0, 5'd21, 1'b0};
        vt[6] = '{0, 1'b0, 1'b1, 5'd6,  1'b0, 5'd6,  1'b0};
        vt[7] = '{2, 1'b1, 1'b0, 5'd0,  1'b0, 5'd7,  1'b0};
        vt[8] = '{0, 1'b0, 1'b1, 5'd10, 1'b0, 5'd10, 1'b0};
        vt[9] = '{1, 1'b0, 1'b1, 5'd3,  1'b1, 5'd10, 1'b1};

        // reset
        repeat (3) @(negedge CLK);
        chk("reset_outputs", {imem_rd, exec_valid, running, halted, program_counter, imem_addr}, 0);
        RST = 1'b0;
        run = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (imem_rd === 1'b1 || running === 1'b1) cnt++;
        end
        chk("idle_without_load", cnt, 0);

        // straight-line program
        load_done = 1'b1;
        for (int i = 0; i < 32; i++) do_instr(2, 1'b0, 1'b0, 5'd0, 1'b0);
        if (WRAP) do_instr(0, 1'b0, 1'b0, 5'd0, 1'b1);
        chk("fetch_count", fetch_cnt, WRAP ? 33 : 32);
        chk("straight_halt_pc", program_counter, WRAP ? 0 : 31);
        leave_halt();

        // table-driven directed sequence
        foreach (fetched[i]) fetched[i] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            do_instr(vt[i].dly, vt[i].ign, vt[i].jmp, vt[i].ja, vt[i].hlt);
            chk("tbl_pc", program_counter, vt[i].exp_pc);
            chk("tbl_halted", halted, vt[i].exp_halt);
        end
        chk("addr5_skipped", fetched[5], 0);
        chk("addr20_fetched", fetched[20], 1);
        leave_halt();

        // run=0 while running: complete, go idle, keep PC, resume there
        do_instr(0, 1'b0, 1'b1, 5'd17, 1'b0);
        wait_fetch(ok);
        wait_exec(ok);
        run       = 1'b0;
        exec_done = 1'b1;
        @(negedge CLK);
        exec_done = 1'b0;
        chk("pause_pc", program_counter, 17);
        chk("pause_flags", {running, imem_rd, exec_valid, halted}, 0);
        repeat (3) @(negedge CLK);
        chk("pause_stays_idle", {running, imem_rd}, 0);
        run = 1'b1;
        @(negedge CLK);
        wait_fetch(ok);
        chk("resume_addr", imem_addr, 17);
        m_pc = 5'd17;

        // abort via load_done during WAIT at PC 12
        do_instr(0, 1'b0, 1'b1, 5'd12, 1'b0);
        wait_fetch(ok);
        chk("abort_fetch_addr", imem_addr, 12);
        @(negedge CLK);
        load_done = 1'b0;
        @(negedge CLK);
        chk("abort_pc", program_counter, 0);
        chk("abort_flags", {imem_rd, exec_valid, running, halted}, 0);
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK);
            if (exec_valid === 1'b1) cnt++;
        end
        chk("abort_no_exec", cnt, 0);
        load_done = 1'b1;
        m_pc = 5'd0;

        // reset in the middle of EXEC
        wait_fetch(ok);
        wait_exec(ok);
        RST = 1'b1;
        @(negedge CLK);
        chk("rst_mid_exec", {imem_rd, exec_valid, running, halted, program_counter}, 0);
        RST = 1'b0;
        m_pc = 5'd0; m_halt = 1'b0;

        // randomized instruction stream against the reference
        for (int n = 0; n < 120; n++) begin
            int         r_dly;
            bit         r_ign, r_jmp, r_hlt;
            logic [4:0] r_ja;
            r_dly = int'($urandom_range(0, 3));
            r_ign = ($urandom_range(0, 3) == 0);
            r_jmp = ($urandom_range(0, 3) == 0);
            r_ja  = 5'($urandom);
            r_hlt = ($urandom_range(0, 24) == 0);
            do_instr(r_dly, r_ign, r_jmp, r_ja, r_hlt);
            if (m_halt) leave_halt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // global watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
